// File: rtl/fb_pkg.sv
// fb_pkg: shared types, widths and command-word layout for the framebuffer Avalon master
package fb_pkg;

    localparam int FB_COORD_W = 12;
    localparam int FB_RGB_W   = 32;
    localparam int FB_RGB_LSB = 0;
    localparam int FB_Y_LSB   = 32;
    localparam int FB_X_LSB   = 44;

    typedef struct packed {
        logic                  write;
        logic [FB_COORD_W-1:0] x;
        logic [FB_COORD_W-1:0] y;
        logic [FB_RGB_W-1:0]   rgb;
    } fb_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_CMD,
        ST_READ_WAIT
    } fb_state_t;

    function automatic logic [63:0] fb_pack(fb_req_t r);
        logic [63:0] w;
        w = '0;
        w[FB_X_LSB +: FB_COORD_W] = r.x;
        w[FB_Y_LSB +: FB_COORD_W] = r.y;
        w[FB_RGB_LSB +: FB_RGB_W] = r.write ? r.rgb : '0;
        return w;
    endfunction

endpackage

// File: rtl/fb_avalon_master_if.sv
// fb_avalon_master_if: pixel request/response handshake plus the Avalon-MM bus
interface fb_avalon_master_if;
    import fb_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [FB_COORD_W-1:0] req_x;
    logic [FB_COORD_W-1:0] req_y;
    logic [FB_RGB_W-1:0]   req_rgb;
    logic                  rsp_valid;
    logic [FB_RGB_W-1:0]   rsp_rgb;
    logic                  rsp_err;
    logic                  ava_write;
    logic                  ava_read;
    logic [63:0]           ava_writedata;
    logic                  ava_waitrequest;
    logic [63:0]           ava_readdata;
    logic                  ava_readdatavalid;

    modport master (
        input  req_valid, req_write, req_x, req_y, req_rgb,
        input  ava_waitrequest, ava_readdata, ava_readdatavalid,
        output req_ready, rsp_valid, rsp_rgb, rsp_err,
        output ava_write, ava_read, ava_writedata
    );

    modport slave (
        output req_valid, req_write, req_x, req_y, req_rgb,
        output ava_waitrequest, ava_readdata, ava_readdatavalid,
        input  req_ready, rsp_valid, rsp_rgb, rsp_err,
        input  ava_write, ava_read, ava_writedata
    );

endinterface

// File: rtl/fb_req_fifo.sv
// fb_req_fifo: synchronous request FIFO with registered full/empty flags and a look-ahead entry
module fb_req_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fb_req_t                din,
    input  logic                   pop,
    output fb_req_t                head,
    output fb_req_t                second,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fb_req_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_n;

    assign count_n = count + CW'(push) - CW'(pop);
    assign head    = mem[rd_ptr];
    assign second  = mem[rd_ptr + AW'(1)];

    // Pointers and occupancy; flags track the post-update occupancy so a pop never frees a slot combinationally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count_n;
            full   <= count_n == CW'(DEPTH);
            empty  <= count_n == '0;
        end
    end

    // Storage needs no reset: entries are only read once counted as valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fb_avalon_master.sv
// fb_avalon_master: queued pixel read/write requests issued one at a time as Avalon-MM transfers
module fb_avalon_master
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    fb_avalon_master_if.master bus,
    output logic               idle,
    output logic               unexp_rdv
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(RD_TIMEOUT + 1);

    fb_state_t           state;
    fb_state_t           state_n;
    fb_req_t             din;
    fb_req_t             head;
    fb_req_t             second;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic                more;
    logic                expire;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_n;
    logic [TW-1:0]       tmr;
    logic [TW-1:0]       tmr_n;
    logic                ava_write_n;
    logic                ava_read_n;
    logic                rsp_valid_n;
    logic                rsp_err_n;
    logic [63:0]         wd_n;
    logic [FB_RGB_W-1:0] rsp_rgb_n;

    assign din           = {bus.req_write, bus.req_x, bus.req_y, bus.req_rgb};
    assign push          = bus.req_valid && !full;
    assign bus.req_ready = !full;
    assign count_n       = count + CW'(push) - CW'(pop);
    assign more          = count > CW'(1);
    // tmr counts cycles since read acceptance; deciding one cycle early lands the registered response on cycle RD_TIMEOUT
    assign expire        = tmr == TW'(RD_TIMEOUT - 1);

    fb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .din    (din),
        .pop    (pop),
        .head   (head),
        .second (second),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    // Next state and next registered outputs; a completing write loads the following entry for gap-free bursts
    always_comb begin
        state_n     = state;
        pop         = 1'b0;
        tmr_n       = tmr;
        ava_write_n = bus.ava_write;
        ava_read_n  = bus.ava_read;
        wd_n        = bus.ava_writedata;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_rgb_n   = '0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    state_n     = head.write ? ST_WRITE : ST_READ_CMD;
                    ava_write_n = head.write;
                    ava_read_n  = !head.write;
                    wd_n        = fb_pack(head);
                end
            end
            ST_WRITE: begin
                if (!bus.ava_waitrequest) begin
                    pop         = 1'b1;
                    state_n     = !more ? ST_IDLE : second.write ? ST_WRITE : ST_READ_CMD;
                    ava_write_n = more && second.write;
                    ava_read_n  = more && !second.write;
                    wd_n        = more ? fb_pack(second) : bus.ava_writedata;
                end
            end
            ST_READ_CMD: begin
                if (!bus.ava_waitrequest) begin
                    pop        = 1'b1;
                    state_n    = ST_READ_WAIT;
                    ava_read_n = 1'b0;
                    tmr_n      = TW'(1);
                end
            end
            ST_READ_WAIT: begin
                tmr_n = tmr + TW'(1);
                if (bus.ava_readdatavalid || expire) begin
                    state_n     = ST_IDLE;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = !bus.ava_readdatavalid;
                    rsp_rgb_n   = bus.ava_readdatavalid ? bus.ava_readdata[FB_RGB_W-1:0] : '0;
                end
            end
        endcase
    end

    // State and every output register; reset drops commands asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= ST_IDLE;
            tmr               <= '0;
            bus.ava_write     <= 1'b0;
            bus.ava_read      <= 1'b0;
            bus.ava_writedata <= '0;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_err       <= 1'b0;
            bus.rsp_rgb       <= '0;
            idle              <= 1'b1;
            unexp_rdv         <= 1'b0;
        end else begin
            state             <= state_n;
            tmr               <= tmr_n;
            bus.ava_write     <= ava_write_n;
            bus.ava_read      <= ava_read_n;
            bus.ava_writedata <= wd_n;
            bus.rsp_valid     <= rsp_valid_n;
            bus.rsp_err       <= rsp_err_n;
            bus.rsp_rgb       <= rsp_rgb_n;
            idle              <= state_n == ST_IDLE && count_n == '0;
            unexp_rdv         <= unexp_rdv || (bus.ava_readdatavalid && state != ST_READ_WAIT);
        end
    end

endmodule

// File: tb/tb_fb_avalon_master.sv
// tb_fb_avalon_master: scoreboard bench for the framebuffer Avalon master
module tb_fb_avalon_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        idle;
    logic        unexp_rdv;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rsp_cnt = 0;
    int          cnt0;
    logic [65:0] ev_q [$];
    int          hs_q [$];
    logic [63:0] exp5 [5];

    fb_avalon_master_if bus ();

    fb_avalon_master #(.FIFO_DEPTH(4), .RD_TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .idle      (idle),
        .unexp_rdv (unexp_rdv)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [63:0] d);
        logic [65:0] e;
        if (ev_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL ev_extra: got kind %0d data %h, required no event", k, d);
        end else begin
            e = ev_q.pop_front();
            chk("ev_order", {k, d}, e);
        end
    endtask

    // Monitor: every write/read handshake and response strobe must match the next expected event
    always @(negedge clk) begin
        if (rst) begin
            if (bus.ava_write || bus.ava_read) chk("cmd_excl", bus.ava_write && bus.ava_read, 0);
            if (bus.ava_write && !bus.ava_waitrequest) begin
                hs_q.push_back(cyc);
                expect_ev(2'd0, bus.ava_writedata);
            end
            if (bus.ava_read && !bus.ava_waitrequest) expect_ev(2'd1, bus.ava_writedata);
            if (bus.rsp_valid) begin
                rsp_cnt++;
                expect_ev(2'd2, {31'b0, bus.rsp_err, bus.rsp_rgb});
            end
        end
    end

    task automatic send(input logic w, input logic [11:0] x, input logic [11:0] y, input logic [31:0] rgb);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_x     = x;
        bus.req_y     = y;
        bus.req_rgb   = rgb;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", bus.req_ready, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!idle && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", idle, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd_hs();
        int n = 0;
        @(negedge clk);
        while (!(bus.ava_read && !bus.ava_waitrequest) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rd_accept_seen", bus.ava_read && !bus.ava_waitrequest, 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp5 = '{64'h0001_0020_C0DE_0000, 64'h0001_1021_C0DE_0001, 64'h0001_2022_C0DE_0002,
                 64'h0001_3023_C0DE_0003, 64'h0001_4024_C0DE_0004};
        bus.req_valid         = 1'b0;
        bus.req_write         = 1'b0;
        bus.req_x             = '0;
        bus.req_y             = '0;
        bus.req_rgb           = '0;
        bus.ava_waitrequest   = 1'b0;
        bus.ava_readdata      = '0;
        bus.ava_readdatavalid = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_idle", idle, 1);
        chk("rst_cmds", {bus.ava_write, bus.ava_read, bus.rsp_valid, bus.rsp_err, unexp_rdv}, 0);
        chk("rst_data", {bus.ava_writedata, bus.rsp_rgb}, 0);
        tick();
        rst = 1'b1;
        tick();

        // Single write held off by waitrequest for three cycles
        bus.ava_waitrequest = 1'b1;
        ev_q.push_back({2'd0, 64'h0006_40C8_AABB_CCDD});
        send(1'b1, 12'd100, 12'd200, 32'hAABB_CCDD);
        @(negedge clk);
        chk("lat_n1_quiet", bus.ava_write, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wr_hold", {bus.ava_write, bus.ava_writedata}, {1'b1, 64'h0006_40C8_AABB_CCDD});
            tick();
            if (i == 2) bus.ava_waitrequest = 1'b0;
        end
        @(negedge clk);
        chk("wr_done_idle", {idle, bus.ava_write}, 2'b10);
        tick();

        // Fill the FIFO behind a stalled write, then drain five writes back to back
        bus.ava_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) ev_q.push_back({2'd0, exp5[i]});
        hs_q.delete();
        for (int i = 0; i < 4; i++) send(1'b1, 12'h010 + 12'(i), 12'h020 + 12'(i), 32'hC0DE_0000 + 32'(i));
        bus.ava_waitrequest = 1'b0;
        bus.req_valid       = 1'b1;
        bus.req_x           = 12'h014;
        bus.req_y           = 12'h024;
        bus.req_rgb         = 32'hC0DE_0004;
        @(negedge clk);
        chk("full_ready_low", bus.req_ready, 0);
        tick();
        send(1'b1, 12'h014, 12'h024, 32'hC0DE_0004);
        wait_idle();
        chk("b2b_count", hs_q.size(), 5);
        if (hs_q.size() == 5) for (int i = 0; i < 4; i++) chk("b2b_gap", hs_q[i+1] - hs_q[i], 1);

        // Read answered two cycles after acceptance
        ev_q.push_back({2'd1, 64'h0000_5007_0000_0000});
        ev_q.push_back({2'd2, 64'h0000_0000_0011_2233});
        cnt0 = rsp_cnt;
        send(1'b0, 12'd5, 12'd7, 32'hFFFF_FFFF);
        wait_rd_hs();
        tick();
        tick();
        bus.ava_readdatavalid = 1'b1;
        bus.ava_readdata      = 64'hDEAD_BEEF_0011_2233;
        tick();
        bus.ava_readdatavalid = 1'b0;
        wait_idle();
        repeat (3) tick();
        chk("rsp_once", rsp_cnt - cnt0, 1);

        // Write, read, write: the trailing write waits for the read response
        ev_q.push_back({2'd0, 64'h0011_1222_1234_5678});
        ev_q.push_back({2'd1, 64'h000A_B0CD_0000_0000});
        ev_q.push_back({2'd2, 64'h0000_0000_CAFE_F00D});
        ev_q.push_back({2'd0, 64'h0033_3444_9ABC_DEF0});
        send(1'b1, 12'h111, 12'h222, 32'h1234_5678);
        send(1'b0, 12'h0AB, 12'h0CD, 32'h0);
        send(1'b1, 12'h333, 12'h444, 32'h9ABC_DEF0);
        wait_rd_hs();
        repeat (4) tick();
        bus.ava_readdatavalid = 1'b1;
        bus.ava_readdata      = 64'hFFFF_FFFF_CAFE_F00D;
        tick();
        bus.ava_readdatavalid = 1'b0;
        wait_idle();
        chk("unexp_clear", unexp_rdv, 0);

        // Read that times out, then a stray data strobe
        ev_q.push_back({2'd1, 64'h0000_1002_0000_0000});
        ev_q.push_back({2'd2, 64'h0000_0001_0000_0000});
        send(1'b0, 12'h001, 12'h002, 32'h0);
        wait_rd_hs();
        for (int k = 1; k <= 8; k++) begin
            tick();
            @(negedge clk);
            if (k < 8) chk("timeout_quiet", bus.rsp_valid, 0);
            else chk("timeout_pulse", {bus.rsp_valid, bus.rsp_err, bus.rsp_rgb}, {2'b11, 32'h0});
        end
        chk("unexp_before_stray", unexp_rdv, 0);
        tick();
        bus.ava_readdatavalid = 1'b1;
        tick();
        bus.ava_readdatavalid = 1'b0;
        @(negedge clk);
        chk("unexp_set", unexp_rdv, 1);
        tick();

        // Reset asserted while a write is stalled with another queued
        bus.ava_waitrequest = 1'b1;
        send(1'b1, 12'h007, 12'h008, 32'h0000_0055);
        send(1'b1, 12'h009, 12'h00A, 32'h0000_0066);
        @(negedge clk);
        chk("stall_wr", bus.ava_write, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_wr", {bus.ava_write, idle, unexp_rdv}, 3'b010);
        tick();
        tick();
        rst = 1'b1;
        bus.ava_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst", {idle, bus.ava_write, bus.ava_read, bus.rsp_valid}, 4'b1000);
            tick();
        end

        chk("ev_drained", ev_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
